interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//   Interrupt sequencer for the multi-cycle MIPS core. It sits between the external
//   interrupt pins (INT, NMI, INTD) and the multi-cycle Controller, and arbitrates NMI
//   against the maskable INT. At an instruction boundary it saves the return PC (EPC),
//   redirects the PC to a handler vector and pulses INA. It then blocks further entries
//   until the handler executes ERET.
// PARAMETERS
//   PC_W        32            width of PC, EPC and vector buses
//   INT_VECTOR  32'h00000080  handler address for maskable INT
//   NMI_VECTOR  32'h00000100  handler address for NMI
// PORTS
//   clk         in   1     core clock; all logic on the rising edge
//   reset       in   1     synchronous reset, active-high
//   INT         in   1     maskable interrupt request, level-sensitive
//   NMI         in   1     non-maskable interrupt, rising-edge-sensitive
//   INTD        in   1     interrupt disable; 1 masks INT only, never NMI
//   instr_done  in   1     Controller is in its last cycle of an instruction (boundary)
//   eret        in   1     Controller is executing ERET (1-cycle pulse)
//   cur_pc      in   PC_W  PC of the next instruction, valid while instr_done=1
//   epc_write   out  1     1-cycle strobe: the DataPath loads epc into EPC
//   epc         out  PC_W  saved return address
//   take_irq    out  1     1-cycle strobe: Controller forces PCSource to vector_pc
//   vector_pc   out  PC_W  handler address; valid while take_irq=1
//   INA         out  1     interrupt acknowledge; pulses with take_irq
//   cause       out  2     00 none, 01 INT, 10 NMI; holds until ERET
//   in_service  out  1     1 while a handler is running
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; nmi_q=0; nmi_pend=0.
//   NMI edge detect: nmi_q<=NMI every cycle; nmi_pend set on NMI&~nmi_q.
//     - nmi_pend clears only in the cycle the sequencer enters SAVE with cause NMI.
//     - Pend is one deep: extra edges while pending merge into the existing pend.
//     - NMI high on the first cycle after reset counts as an edge.
//   int_req = INT & ~INTD, sampled combinationally in the instr_done cycle only.
//   Registered outputs; FSM states:
//     IDLE    -> SAVE when instr_done & (nmi_pend | int_req); otherwise stay.
//                Priority: NMI over INT. The winner is latched into cause.
//                cur_pc is latched into epc.
//     SAVE    -> VECTOR unconditionally. epc_write=1 for this cycle only.
//     VECTOR  -> SERVICE unconditionally. take_irq=1 and INA=1 for this cycle only.
//                vector_pc = NMI_VECTOR if cause=10, else INT_VECTOR.
//     SERVICE -> IDLE on eret. in_service=1 throughout SERVICE.
//                On exit: cause<=00, in_service<=0.
//   Latency: instr_done in cycle N -> epc_write in N+1 -> take_irq/INA in N+2 ->
//     in_service=1 from N+3.
//   No nesting: while not IDLE, no new entry is taken, including NMI.
//     - An NMI edge arriving in SAVE/VECTOR/SERVICE sets nmi_pend.
//     - That pend is taken at the first instr_done after the return to IDLE.
//   eret is ignored outside SERVICE. instr_done is ignored outside IDLE.
//   eret together with instr_done in SERVICE: the FSM goes to IDLE only.
//     The next entry is evaluated at the following instr_done, never the same cycle.
//   INT or INTD changing after the sample cycle does not abort a sequence in progress.
//   Reset mid-sequence (any state):
//     - Immediate return to IDLE with all outputs 0 on the next edge.
//     - Any pending NMI is discarded.
//   epc holds its value after SAVE until the next SAVE; reset clears it to 0.
// TESTING
//   1. INT=1, INTD=0, instr_done pulse with cur_pc=0x40 at cycle N:
//      epc_write=1 with epc=0x40 at N+1; INA=take_irq=1 with vector_pc=0x80 at N+2;
//      cause=01; eret -> cause=00, in_service=0.
//   2. INT=1, INTD=1, NMI low, repeated instr_done: no epc_write, INA or take_irq ever.
//   3. NMI rising edge and INT=1 before the same instr_done:
//      cause=10, vector_pc=0x100, nmi_pend cleared; INT remains unserviced.
//   4. NMI edge during an INT SERVICE: no action until eret;
//      the next instr_done (cur_pc=0x200) gives epc=0x200 and cause=10.
//   5. Reset asserted in the VECTOR cycle: next cycle state=IDLE and all outputs 0;
//      an NMI pend set beforehand is gone; NMI held high after reset produces one entry.
//   6. eret and instr_done in the same SERVICE cycle with INT=1:
//      IDLE next cycle; entry is taken only at the subsequent instr_done.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates NMI (edge) over maskable INT (level) at instruction
// boundaries, saves EPC, redirects the PC to a handler vector and blocks re-entry until ERET.
module interrupt_sequencer #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] INT_VECTOR = 'h00000080,
  parameter logic [PC_W-1:0] NMI_VECTOR = 'h00000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            INT,
  input  logic            NMI,
  input  logic            INTD,
  input  logic            instr_done,
  input  logic            eret,
  input  logic [PC_W-1:0] cur_pc,
  output logic            epc_write,
  output logic [PC_W-1:0] epc,
  output logic            take_irq,
  output logic [PC_W-1:0] vector_pc,
  output logic            INA,
  output logic [1:0]      cause,
  output logic            in_service,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    VECTOR  = 2'd2,
    SERVICE = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_INT  = 2'b01;
  localparam logic [1:0] CAUSE_NMI  = 2'b10;

  state_t state;
  logic   nmi_q;
  logic   nmi_pend;
  logic   int_req;

  // Strobe semantics: epc_write, take_irq and INA are single-cycle pulses with no
  // back-pressure; epc/vector_pc are valid in the cycle their strobe is high.
  assign int_req   = INT & ~INTD;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      nmi_q      <= 1'b0;
      nmi_pend   <= 1'b0;
      epc_write  <= 1'b0;
      epc        <= '0;
      take_irq   <= 1'b0;
      vector_pc  <= '0;
      INA        <= 1'b0;
      cause      <= CAUSE_NONE;
      in_service <= 1'b0;
    end else begin
      nmi_q     <= NMI;
      if (NMI && !nmi_q) nmi_pend <= 1'b1;
      epc_write <= 1'b0;
      take_irq  <= 1'b0;
      INA       <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_done && (nmi_pend || int_req)) begin
            state     <= SAVE;
            epc       <= cur_pc;
            epc_write <= 1'b1;
            // Clearing here wins over a coincident edge: that edge merges into this entry.
            if (nmi_pend) begin
              cause    <= CAUSE_NMI;
              nmi_pend <= 1'b0;
            end else begin
              cause    <= CAUSE_INT;
            end
          end
        end
        SAVE: begin
          state     <= VECTOR;
          take_irq  <= 1'b1;
          INA       <= 1'b1;
          vector_pc <= (cause == CAUSE_NMI) ? NMI_VECTOR : INT_VECTOR;
        end
        VECTOR: begin
          state      <= SERVICE;
          in_service <= 1'b1;
          vector_pc  <= '0;
        end
        SERVICE: begin
          if (eret) begin
            state      <= IDLE;
            cause      <= CAUSE_NONE;
            in_service <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: stimulus pushes expected SAVE/VECTOR events with
// their cycle stamps; a negedge monitor pops and compares every strobe the DUT raises.
module tb_interrupt_sequencer;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            INT = 1'b0;
  logic            NMI = 1'b0;
  logic            INTD = 1'b0;
  logic            instr_done = 1'b0;
  logic            eret = 1'b0;
  logic [PC_W-1:0] cur_pc = '0;
  logic            epc_write;
  logic [PC_W-1:0] epc;
  logic            take_irq;
  logic [PC_W-1:0] vector_pc;
  logic            INA;
  logic [1:0]      cause;
  logic            in_service;
  logic [1:0]      dbg_state;

  // Event record: {cycle[15:0], kind[1:0] (1=SAVE, 2=VECTOR), cause[1:0], pc[31:0]}
  logic [51:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] cyc    = '0;

  interrupt_sequencer #(
    .PC_W      (PC_W),
    .INT_VECTOR(32'h00000080),
    .NMI_VECTOR(32'h00000100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .INT       (INT),
    .NMI       (NMI),
    .INTD      (INTD),
    .instr_done(instr_done),
    .eret      (eret),
    .cur_pc    (cur_pc),
    .epc_write (epc_write),
    .epc       (epc),
    .take_irq  (take_irq),
    .vector_pc (vector_pc),
    .INA       (INA),
    .cause     (cause),
    .in_service(in_service),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [51:0] act;
    logic [51:0] exp;
    if (epc_write || take_irq) begin
      act = {cyc, (epc_write ? 2'd1 : 2'd2), cause, (epc_write ? epc : vector_pc)};
      if (epc_write && take_irq) check("strobe_overlap", 64'(act), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        check("event", 64'(act), 64'(exp));
      end
    end
    if (INA || take_irq) check("ina_vs_take_irq", 64'(INA), 64'(take_irq));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // instr_done pulse that must start an entry; leaves the bench in the SAVE cycle
  task automatic pulse_entry(input logic [31:0] pc, input logic [1:0] c, input logic [31:0] vec);
    exp_q.push_back({cyc + 16'd1, 2'd1, c, pc});
    exp_q.push_back({cyc + 16'd2, 2'd2, c, vec});
    instr_done = 1'b1;
    cur_pc     = pc;
    tick();
    instr_done = 1'b0;
  endtask

  // instr_done pulse that must be ignored (monitor flags any strobe)
  task automatic pulse_none(input logic [31:0] pc);
    instr_done = 1'b1;
    cur_pc     = pc;
    tick();
    instr_done = 1'b0;
    tick();
  endtask

  // From the SAVE cycle: step into SERVICE and check the in-service status
  task automatic enter_service(input string name, input logic [1:0] c);
    tick();
    tick();
    check({name, "_service"}, {61'd0, in_service, dbg_state}, {61'd0, 1'b1, 2'd3});
    check({name, "_cause"}, 64'(cause), 64'(c));
  endtask

  task automatic do_eret(input string name);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check({name, "_after_eret"}, {60'd0, in_service, cause, dbg_state != 2'd0}, 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {epc_write, take_irq, INA, in_service, cause, dbg_state},
          8'd0);
    check({name, "_buses"}, {epc, vector_pc}, 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    do_reset();
    check_all_zero("reset_state");

    // 1: maskable INT entry
    INT = 1'b1;
    INTD = 1'b0;
    pulse_entry(32'h40, 2'b01, 32'h80);
    enter_service("t1", 2'b01);
    INT = 1'b0;
    do_eret("t1");

    // 2: INT masked by INTD, NMI low: nothing happens, epc holds
    INT = 1'b1;
    INTD = 1'b1;
    for (int i = 0; i < 4; i++) pulse_none(32'h1000 + 32'(i * 4));
    check("t2_idle", 64'(dbg_state), 64'd0);
    check("t2_epc_hold", 64'(epc), 64'h40);

    // 3: NMI edge and INT both present at the same boundary: NMI wins
    INTD = 1'b0;
    NMI = 1'b1;
    tick();
    NMI = 1'b0;
    tick();
    pulse_entry(32'h44, 2'b10, 32'h100);
    INT = 1'b0;
    enter_service("t3", 2'b10);
    do_eret("t3");
    pulse_none(32'h48);
    check("t3_pend_cleared", 64'(dbg_state), 64'd0);

    // 4: NMI edge during INT service is held until after eret
    INT = 1'b1;
    pulse_entry(32'h60, 2'b01, 32'h80);
    enter_service("t4a", 2'b01);
    NMI = 1'b1;
    tick();
    NMI = 1'b0;
    tick();
    pulse_none(32'h70);
    check("t4_no_nesting", 64'(dbg_state), 64'd3);
    INT = 1'b0;
    do_eret("t4a");
    pulse_entry(32'h200, 2'b10, 32'h100);
    enter_service("t4b", 2'b10);
    do_eret("t4b");

    // 5a: reset in VECTOR discards the sequence and a pending NMI
    INT = 1'b1;
    pulse_entry(32'h90, 2'b01, 32'h80);
    NMI = 1'b1;
    INT = 1'b0;
    tick();
    NMI = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t5_reset_in_vector");
    pulse_none(32'hA0);
    check("t5_pend_discarded", 64'(dbg_state), 64'd0);

    // 5b: NMI held high across reset counts as exactly one edge
    NMI = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pulse_entry(32'hB0, 2'b10, 32'h100);
    enter_service("t5b", 2'b10);
    do_eret("t5b");
    pulse_none(32'hC0);
    check("t5_single_entry", 64'(dbg_state), 64'd0);
    NMI = 1'b0;

    // 6: eret with instr_done in SERVICE only returns to IDLE
    INT = 1'b1;
    pulse_entry(32'hD0, 2'b01, 32'h80);
    enter_service("t6a", 2'b01);
    eret = 1'b1;
    instr_done = 1'b1;
    cur_pc = 32'hE0;
    tick();
    eret = 1'b0;
    instr_done = 1'b0;
    check("t6_idle_only", 64'(dbg_state), 64'd0);
    tick();
    check("t6_still_idle", {62'd0, dbg_state}, 64'd0);
    pulse_entry(32'hF0, 2'b01, 32'h80);
    INT = 1'b0;
    enter_service("t6b", 2'b01);
    do_eret("t6b");
    check("t6_epc", 64'(epc), 64'hF0);

    tick();
    tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
